// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction fetch/decode/exec sequencer driving the two-register ALU datapath
module control_sequencer #(
    parameter int OPCODE_W = 7,
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [OPCODE_W+DATA_W-1:0] im_data,
    input  logic                       alu_z,
    input  logic                       alu_n,
    input  logic                       alu_c,
    output logic [PC_W-1:0]            pc,
    output logic                       lRegA,
    output logic                       lRegB,
    output logic                       sMuxA,
    output logic [1:0]                 sMuxB,
    output logic [2:0]                 sAlu,
    output logic [DATA_W-1:0]          lit,
    output logic                       halt,
    output logic                       illegal
);

    localparam int IW = OPCODE_W + DATA_W;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            state;
    logic [IW-1:0]     ir;
    logic              st_z, st_n, st_c;
    // Decoded control word {lRegA, lRegB, sMuxA, sMuxB[1:0], sAlu[2:0], illegal}
    logic [8:0]        cw_q;
    logic [8:0]        dec;
    logic [OPCODE_W-1:0] d_op;
    logic [OPCODE_W-1:0] x_op;
    logic              taken;
    logic              upd_status;
    logic              is_halt;
    logic              active;

    function automatic logic [8:0] cw(input logic la, input logic lb, input logic sa,
                                      input logic [1:0] sb, input logic [2:0] alu);
        return {la, lb, sa, sb, alu, 1'b0};
    endfunction

    // Decode the ROM word arriving in DECODE; muxA=1 selects zero so MOVs are 0+operand
    always_comb begin
        d_op = im_data[IW-1 -: OPCODE_W];
        dec  = '0;
        if (d_op != '1) begin
            case (int'(d_op))
                'h00: dec = cw(1'b1, 1'b0, 1'b1, 2'b00, 3'b000); // MOV A,B
                'h01: dec = cw(1'b0, 1'b1, 1'b1, 2'b10, 3'b000); // MOV B,A
                'h02: dec = cw(1'b1, 1'b0, 1'b1, 2'b01, 3'b000); // MOV A,Lit
                'h03: dec = cw(1'b0, 1'b1, 1'b1, 2'b01, 3'b000); // MOV B,Lit
                'h04: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b000); // ADD A,B
                'h05: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b000); // ADD B,A
                'h06: dec = cw(1'b1, 1'b0, 1'b0, 2'b01, 3'b000); // ADD A,Lit
                'h07: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b001); // SUB A,B
                'h08: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b001); // SUB B,A
                'h09: dec = cw(1'b1, 1'b0, 1'b0, 2'b01, 3'b001); // SUB A,Lit
                'h0A: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b010); // AND A,B
                'h0B: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b010); // AND B,A
                'h0C: dec = cw(1'b1, 1'b0, 1'b0, 2'b01, 3'b010); // AND A,Lit
                'h0D: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b011); // OR A,B
                'h0E: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b011); // OR B,A
                'h0F: dec = cw(1'b1, 1'b0, 1'b0, 2'b01, 3'b011); // OR A,Lit
                'h10: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b100); // NOT A
                'h11: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b100); // NOT B,A
                'h12: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b101); // XOR A,B
                'h13: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b101); // XOR B,A
                'h14: dec = cw(1'b1, 1'b0, 1'b0, 2'b01, 3'b101); // XOR A,Lit
                'h15: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b110); // SHL A
                'h16: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b110); // SHL B,A
                'h17: dec = cw(1'b1, 1'b0, 1'b0, 2'b00, 3'b111); // SHR A
                'h18: dec = cw(1'b0, 1'b1, 1'b0, 2'b00, 3'b111); // SHR B,A
                'h19: dec = cw(1'b0, 1'b0, 1'b0, 2'b00, 3'b001); // CMP A,B
                'h1A: dec = cw(1'b0, 1'b0, 1'b0, 2'b01, 3'b001); // CMP A,Lit
                'h1B, 'h1C, 'h1D, 'h1E, 'h1F,
                'h20, 'h21, 'h22, 'h23: dec = '0;                // jumps, NOP
                default: dec = 9'b0_0000_0001;                   // undefined opcode
            endcase
        end
    end

    // Branch condition and status-update qualification for the instruction in ir
    always_comb begin
        x_op       = ir[IW-1 -: OPCODE_W];
        is_halt    = (x_op == '1);
        upd_status = (x_op <= OPCODE_W'(26));
        taken      = 1'b0;
        case (int'(x_op))
            'h1B: taken = 1'b1;
            'h1C: taken = st_z;
            'h1D: taken = !st_z;
            'h1E: taken = !st_z && !st_n;
            'h1F: taken = !st_n;
            'h20: taken = st_n;
            'h21: taken = st_z || st_n;
            'h22: taken = st_c;
            default: taken = 1'b0;
        endcase
    end

    // Sequencer state, pc, ir, decoded word and status register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            cw_q  <= '0;
            st_z  <= 1'b0;
            st_n  <= 1'b0;
            st_c  <= 1'b0;
        end else if (en) begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= im_data;
                    cw_q  <= dec;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= taken ? PC_W'(ir[DATA_W-1:0]) : pc + 1'b1;
                        state <= S_FETCH;
                        if (upd_status) begin
                            st_z <= alu_z;
                            st_n <= alu_n;
                            st_c <= alu_c;
                        end
                    end
                end
                default:  state <= S_HALT;
            endcase
        end
    end

    // Controls only reach the datapath in an enabled, non-reset EXEC cycle
    always_comb begin
        active  = !rst && en && (state == S_EXEC);
        lRegA   = active & cw_q[8];
        lRegB   = active & cw_q[7];
        sMuxA   = active & cw_q[6];
        sMuxB   = active ? cw_q[5:4] : 2'b00;
        sAlu    = active ? cw_q[3:1] : 3'b000;
        illegal = active & cw_q[0];
        lit     = active ? ir[DATA_W-1:0] : '0;
        halt    = !rst && (state == S_HALT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against an instruction-level model
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [14:0] im_data = '0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0;
    logic [7:0]  pc;
    logic        lRegA, lRegB, sMuxA, halt, illegal;
    logic [1:0]  sMuxB;
    logic [2:0]  sAlu;
    logic [7:0]  lit;

    control_sequencer #(.OPCODE_W(7), .DATA_W(8), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .im_data(im_data),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .pc(pc), .lRegA(lRegA), .lRegB(lRegB), .sMuxA(sMuxA), .sMuxB(sMuxB),
        .sAlu(sAlu), .lit(lit), .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected control word per opcode: {lRegA, lRegB, sMuxA, sMuxB, sAlu, illegal}
    logic [8:0]  cw_tab [0:127];
    logic [14:0] rom [0:255];

    task automatic tab(input int op, input bit la, input bit lb, input bit sa,
                       input bit [1:0] sb, input bit [2:0] alu);
        cw_tab[op] = {la, lb, sa, sb, alu, 1'b0};
    endtask

    // Instruction-level model: enabled-cycle phase counter, pc, flags, halted
    int          m_phase = 0;
    logic [7:0]  m_pc = '0, m_pc_prev = '0;
    logic        m_z = 0, m_n = 0, m_c = 0, m_halt = 0, m_valid = 0;
    logic [14:0] m_ir = '0;

    function automatic bit jump_taken(input logic [6:0] op);
        case (op)
            7'h1B:   return 1'b1;
            7'h1C:   return m_z;
            7'h1D:   return !m_z;
            7'h1E:   return !m_z && !m_n;
            7'h1F:   return !m_n;
            7'h20:   return m_n;
            7'h21:   return m_z || m_n;
            7'h22:   return m_c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit r, input bit e);
        logic [17:0] obs, exp;
        logic [2:0]  flags;
        @(negedge clk);
        rst = r;
        en = e;
        flags = 3'($urandom);
        {alu_z, alu_n, alu_c} = flags;
        im_data = rom[m_pc_prev];
        #1;
        obs = {lRegA, lRegB, sMuxA, sMuxB, sAlu, illegal, halt, lit};
        if (r)                       exp = '0;
        else if (m_halt)             exp = {9'b0, 1'b1, 8'h00};
        else if (e && m_phase == 2)  exp = {cw_tab[m_ir[14:8]], 1'b0, m_ir[7:0]};
        else                         exp = '0;
        check("ctl", 32'(obs), 32'(exp));
        if (m_valid) check("pc", 32'(pc), 32'(m_pc));
        @(posedge clk);
        m_pc_prev = m_pc;
        if (r) begin
            m_valid = 1; m_phase = 0; m_pc = '0; m_halt = 0;
            {m_z, m_n, m_c} = 3'b000;
        end else if (e && m_valid && !m_halt) begin
            if (m_phase == 1) m_ir = im_data;
            if (m_phase == 2) begin
                if (m_ir[14:8] == 7'h7F) begin
                    m_halt = 1;
                end else begin
                    m_pc = jump_taken(m_ir[14:8]) ? m_ir[7:0] : m_pc + 8'd1;
                    if (m_ir[14:8] <= 7'h1A) {m_z, m_n, m_c} = flags;
                end
            end
            if (!m_halt) m_phase = (m_phase + 1) % 3;
        end
    endtask

    task automatic run(input int n, input int en_pct, input int rst_per_1000);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 999) < rst_per_1000, $urandom_range(0, 99) < en_pct);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 15'h2300;
    endtask

    task automatic random_rom();
        int r;
        logic [6:0] op;
        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      op = 7'($urandom_range(0, 'h1A));
            else if (r < 75) op = 7'($urandom_range('h1B, 'h22));
            else if (r < 85) op = 7'h23;
            else if (r < 98) op = 7'($urandom_range('h24, 'h7E));
            else             op = 7'h7F;
            rom[a] = {op, 8'($urandom)};
        end
    endtask

    initial begin
        for (int op = 0; op < 128; op++) cw_tab[op] = 9'b1;
        tab('h00,1,0,1,2'b00,3'd0); tab('h01,0,1,1,2'b10,3'd0);
        tab('h02,1,0,1,2'b01,3'd0); tab('h03,0,1,1,2'b01,3'd0);
        for (int k = 0; k < 5; k++) begin
            // ADD, SUB, AND, OR, XOR families: (A,B) (B,A) (A,Lit)
            int base, alu;
            base = (k < 4) ? 'h04 + 3 * k : 'h12;
            alu  = (k < 4) ? k : 5;
            tab(base,     1,0,0,2'b00,3'(alu));
            tab(base + 1, 0,1,0,2'b00,3'(alu));
            tab(base + 2, 1,0,0,2'b01,3'(alu));
        end
        tab('h10,1,0,0,2'b00,3'd4); tab('h11,0,1,0,2'b00,3'd4);
        tab('h15,1,0,0,2'b00,3'd6); tab('h16,0,1,0,2'b00,3'd6);
        tab('h17,1,0,0,2'b00,3'd7); tab('h18,0,1,0,2'b00,3'd7);
        tab('h19,0,0,0,2'b00,3'd1); tab('h1A,0,0,0,2'b01,3'd1);
        for (int op = 'h1B; op <= 'h23; op++) cw_tab[op] = '0;
        cw_tab['h7F] = '0;

        // Directed program: MOV, CMP/JEQ, illegal, ADD, JMP to end-of-ROM NOP and wrap
        clear_rom();
        rom[0] = 15'h0205; rom[1] = 15'h1A05; rom[2] = 15'h1C06;
        rom[3] = 15'h5000; rom[4] = 15'h0400; rom[5] = 15'h1BFE;
        rom[6] = 15'h1D03; rom[8'hFE] = 15'h2300; rom[8'hFF] = 15'h2300;
        step(1, 0); step(1, 1);
        run(120, 100, 0);
        run(300, 70, 0);
        run(300, 85, 8);

        // Halt at pc=3, held, then cleared by reset
        clear_rom();
        rom[0] = 15'h0211; rom[1] = 15'h0400; rom[2] = 15'h2300; rom[3] = 15'h7F00;
        step(1, 1);
        run(40, 100, 0);
        run(20, 50, 0);
        step(1, 0);
        run(30, 100, 0);

        // Random programs with random stalls and occasional resets
        for (int p = 0; p < 6; p++) begin
            random_rom();
            step(1, $urandom_range(0, 1));
            run(1300, 80, 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
